// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, memop codes,
// FSM states and the lane-steering helpers used by the top and load_align.
package mem_access_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;

   localparam logic [RegAddrBus-1:0] NopRegAddr = '0;

   typedef enum logic [3:0] {
      MemOpNone = 4'd0,
      MemOpLB   = 4'd1,
      MemOpLBU  = 4'd2,
      MemOpLH   = 4'd3,
      MemOpLHU  = 4'd4,
      MemOpLW   = 4'd5,
      MemOpSB   = 4'd6,
      MemOpSH   = 4'd7,
      MemOpSW   = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      MemIdle = 2'd0,
      MemBusy = 2'd1,
      MemDone = 2'd2
   } mem_state_t;

   function automatic logic is_load(input logic [3:0] op);
      case (op)
         MemOpLB, MemOpLBU, MemOpLH, MemOpLHU, MemOpLW: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      case (op)
         MemOpSB, MemOpSH, MemOpSW: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   function automatic logic is_mem_op(input logic [3:0] op);
      return is_load(op) || is_store(op);
   endfunction

   function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] offset);
      case (op)
         MemOpLH, MemOpLHU, MemOpSH: return ~offset[0];
         MemOpLW, MemOpSW:           return (offset == 2'b00);
         default:                    return 1'b1;
      endcase
   endfunction

   // Big-endian lanes: byte offset 0 lives in bits 31:24, i.e. sel bit 3.
   function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] offset);
      case (op)
         MemOpLB, MemOpLBU, MemOpSB: return 4'b1000 >> offset;
         MemOpLH, MemOpLHU, MemOpSH: return offset[1] ? 4'b0011 : 4'b1100;
         MemOpLW, MemOpSW:           return 4'b1111;
         default:                    return 4'b0000;
      endcase
   endfunction

   function automatic logic [RegBus-1:0] store_lanes(input logic [3:0] op,
                                                      input logic [RegBus-1:0] rt);
      case (op)
         MemOpSB: return {4{rt[7:0]}};
         MemOpSH: return {2{rt[15:0]}};
         MemOpSW: return rt;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load formatter: picks the addressed big-endian lane out of the bus word and
// sign- or zero-extends it according to the load opcode.
module load_align
   import mem_access_pkg::*;
(
   input  logic [3:0]        op,
   input  logic [1:0]        offset,
   input  logic [RegBus-1:0] rdata,
   output logic [RegBus-1:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[31:24];
      case (offset)
         2'd0:    byte_lane = rdata[31:24];
         2'd1:    byte_lane = rdata[23:16];
         2'd2:    byte_lane = rdata[15:8];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = offset[1] ? rdata[15:0] : rdata[31:16];

      data = '0;
      case (op)
         MemOpLB:  data = {{24{byte_lane[7]}}, byte_lane};
         MemOpLBU: data = {24'd0, byte_lane};
         MemOpLH:  data = {{16{half_lane[15]}}, half_lane};
         MemOpLHU: data = {16'd0, half_lane};
         MemOpLW:  data = rdata;
         default:  data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: single-outstanding req/ack data-bus master
// that stalls the pipe until the access finishes and drives MEM/WB.
module mem_access
   import mem_access_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RegAddrBus-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [RegBus-1:0]     ex_wdata,
   input  logic [3:0]            ex_memop,
   input  logic [RegBus-1:0]     ex_memaddr,
   input  logic [RegBus-1:0]     ex_memdata,
   output logic [RegAddrBus-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [RegBus-1:0]     mem_wdata,
   output logic                  stallreq,
   output logic                  exc_align,
   output logic                  dbus_req,
   output logic                  dbus_we,
   output logic [RegBus-1:0]     dbus_addr,
   output logic [3:0]            dbus_sel,
   output logic [RegBus-1:0]     dbus_wdata,
   input  logic [RegBus-1:0]     dbus_rdata,
   input  logic                  dbus_ack
);

   mem_state_t        state;
   mem_state_t        state_next;
   logic [RegBus-1:0] ldbuf;
   logic [RegBus-1:0] ld_fmt;
   logic              op_mem;
   logic              op_load;
   logic              op_store;
   logic              op_aligned;
   logic              issue;

   assign op_mem     = is_mem_op(ex_memop);
   assign op_load    = is_load(ex_memop);
   assign op_store   = is_store(ex_memop);
   assign op_aligned = is_aligned(ex_memop, ex_memaddr[1:0]);
   assign issue      = (state == MemIdle) && op_mem && op_aligned;

   // EX/MEM holds the instruction while stalled, so its op/offset are still
   // valid on the ack edge and can steer the formatter directly.
   load_align u_load_align (
      .op     (ex_memop),
      .offset (ex_memaddr[1:0]),
      .rdata  (dbus_rdata),
      .data   (ld_fmt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MemIdle;
      end else begin
         state <= state_next;
      end
   end

   // Bus fields are loaded at issue and frozen until the ack edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_sel   <= '0;
         dbus_wdata <= '0;
         ldbuf      <= '0;
      end else if (issue) begin
         dbus_req   <= 1'b1;
         dbus_we    <= op_store;
         dbus_addr  <= {ex_memaddr[31:2], 2'b00};
         dbus_sel   <= lane_sel(ex_memop, ex_memaddr[1:0]);
         dbus_wdata <= store_lanes(ex_memop, ex_memdata);
      end else if ((state == MemBusy) && dbus_ack) begin
         dbus_req   <= 1'b0;
         ldbuf      <= ld_fmt;
      end
   end

   always_comb begin
      state_next = state;
      stallreq   = 1'b0;
      exc_align  = 1'b0;
      mem_wd     = ex_wd;
      mem_wreg   = ex_wreg;
      mem_wdata  = ex_wdata;

      case (state)
         MemIdle: if (issue) state_next = MemBusy;
         MemBusy: if (dbus_ack) state_next = MemDone;
         MemDone: state_next = MemIdle;
         default: state_next = MemIdle;
      endcase

      stallreq = issue || (state == MemBusy);

      if (op_mem && !op_aligned) begin
         exc_align = (state == MemIdle);
         mem_wreg  = 1'b0;
      end else if (stallreq || op_store) begin
         mem_wreg  = 1'b0;
      end else if (op_load) begin
         mem_wdata = ldbuf;
      end

      // Keep MEM/WB seeing a NOP for as long as reset is held.
      if (rst) begin
         stallreq  = 1'b0;
         exc_align = 1'b0;
         mem_wd    = NopRegAddr;
         mem_wreg  = 1'b0;
         mem_wdata = '0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by random
// memory/non-memory ops checked against a byte-arithmetic reference model.
module tb_mem_access;

   localparam int OpNone = 0;
   localparam int OpLB   = 1;
   localparam int OpLBU  = 2;
   localparam int OpLH   = 3;
   localparam int OpLHU  = 4;
   localparam int OpLW   = 5;
   localparam int OpSB   = 6;
   localparam int OpSH   = 7;
   localparam int OpSW   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_memaddr;
   logic [31:0] ex_memdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq;
   logic        exc_align;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mem_access dut (
      .clk        (clk),
      .rst        (rst),
      .ex_wd      (ex_wd),
      .ex_wreg    (ex_wreg),
      .ex_wdata   (ex_wdata),
      .ex_memop   (ex_memop),
      .ex_memaddr (ex_memaddr),
      .ex_memdata (ex_memdata),
      .mem_wd     (mem_wd),
      .mem_wreg   (mem_wreg),
      .mem_wdata  (mem_wdata),
      .stallreq   (stallreq),
      .exc_align  (exc_align),
      .dbus_req   (dbus_req),
      .dbus_we    (dbus_we),
      .dbus_addr  (dbus_addr),
      .dbus_sel   (dbus_sel),
      .dbus_wdata (dbus_wdata),
      .dbus_rdata (dbus_rdata),
      .dbus_ack   (dbus_ack)
   );

   // Reference model: access size in bytes, 0 for anything that is not a memop.
   function automatic int opSize(input int op);
      case (op)
         OpLB, OpLBU, OpSB: return 1;
         OpLH, OpLHU, OpSH: return 2;
         OpLW, OpSW:        return 4;
         default:           return 0;
      endcase
   endfunction

   function automatic bit isLoad(input int op);
      return (op >= OpLB) && (op <= OpLW);
   endfunction

   function automatic bit isStore(input int op);
      return (op >= OpSB) && (op <= OpSW);
   endfunction

   function automatic bit isAligned(input int op, input logic [31:0] addr);
      return (opSize(op) == 0) || ((addr % opSize(op)) == 0);
   endfunction

   function automatic logic [3:0] expSel(input int op, input logic [1:0] off);
      int size = opSize(op);
      return 4'(((1 << size) - 1) << (4 - size - int'(off)));
   endfunction

   function automatic logic [31:0] expWdata(input int op, input logic [31:0] rt);
      case (opSize(op))
         1:       return 32'(rt[7:0]) * 32'h0101_0101;
         2:       return 32'(rt[15:0]) * 32'h0001_0001;
         default: return rt;
      endcase
   endfunction

   function automatic logic [31:0] expLoad(input int op, input logic [1:0] off,
                                           input logic [31:0] rdata);
      int          size = opSize(op);
      logic [31:0] mask;
      logic [31:0] v;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v    = (rdata >> (8 * (4 - size - int'(off)))) & mask;
      if (((op == OpLB) || (op == OpLH)) && v[8 * size - 1]) v = v | ~mask;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int op, input logic [31:0] addr, input logic [31:0] rt,
                                input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
      ex_memop   = 4'(op);
      ex_memaddr = addr;
      ex_memdata = rt;
      ex_wd      = wd;
      ex_wreg    = wreg;
      ex_wdata   = wdata;
   endtask

   // Aligned memory op with ack arriving after `delay` idle BUSY cycles.
   task automatic runMemOp(input int op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] rdata, input int delay);
      int         stalls = 0;
      logic [4:0] wd     = 5'($urandom_range(1, 31));
      @(negedge clk);
      applyStimulus(op, addr, rt, wd, 1'b1, $urandom);
      dbus_ack = 1'b0;
      #1;
      if (stallreq) stalls++;
      checkOutput("idle_req", 32'(dbus_req), 32'd0);
      checkOutput("idle_wreg", 32'(mem_wreg), 32'd0);
      for (int k = 0; k <= delay; k++) begin
         @(negedge clk);
         dbus_ack   = (k == delay);
         dbus_rdata = (k == delay) ? rdata : $urandom;
         #1;
         if (stallreq) stalls++;
         checkOutput("busy_req", 32'(dbus_req), 32'd1);
         checkOutput("busy_we", 32'(dbus_we), 32'(isStore(op)));
         checkOutput("busy_addr", dbus_addr, {addr[31:2], 2'b00});
         checkOutput("busy_sel", 32'(dbus_sel), 32'(expSel(op, addr[1:0])));
         if (isStore(op)) checkOutput("busy_wdata", dbus_wdata, expWdata(op, rt));
         checkOutput("busy_wreg", 32'(mem_wreg), 32'd0);
         checkOutput("busy_wd", 32'(mem_wd), 32'(wd));
      end
      @(negedge clk);
      dbus_ack   = 1'b0;
      dbus_rdata = $urandom;
      #1;
      if (stallreq) stalls++;
      checkOutput("stall_cycles", 32'(stalls), 32'(delay + 2));
      checkOutput("done_req", 32'(dbus_req), 32'd0);
      checkOutput("done_wreg", 32'(mem_wreg), 32'(isLoad(op)));
      checkOutput("done_wd", 32'(mem_wd), 32'(wd));
      if (isLoad(op)) checkOutput("load_data", mem_wdata, expLoad(op, addr[1:0], rdata));
   endtask

   task automatic runMisaligned(input int op, input logic [31:0] addr);
      @(negedge clk);
      applyStimulus(op, addr, $urandom, 5'd3, 1'b1, $urandom);
      #1;
      checkOutput("mis_exc", 32'(exc_align), 32'd1);
      checkOutput("mis_stall", 32'(stallreq), 32'd0);
      checkOutput("mis_wreg", 32'(mem_wreg), 32'd0);
      checkOutput("mis_req", 32'(dbus_req), 32'd0);
      @(negedge clk);
      applyStimulus(OpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      #1;
      checkOutput("mis_exc_next", 32'(exc_align), 32'd0);
      checkOutput("mis_req_next", 32'(dbus_req), 32'd0);
   endtask

   task automatic runPassthrough(input int op, input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata, input logic ack);
      @(negedge clk);
      applyStimulus(op, $urandom, $urandom, wd, wreg, wdata);
      dbus_ack = ack;
      #1;
      checkOutput("pass_wdata", mem_wdata, wdata);
      checkOutput("pass_wd", 32'(mem_wd), 32'(wd));
      checkOutput("pass_wreg", 32'(mem_wreg), 32'(wreg));
      checkOutput("pass_stall", 32'(stallreq), 32'd0);
      checkOutput("pass_req", 32'(dbus_req), 32'd0);
      dbus_ack = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      dbus_ack   = 1'b0;
      dbus_rdata = 32'h0;
      applyStimulus(OpLW, 32'h100, 32'h1234_5678, 5'd3, 1'b1, 32'hCAFE_F00D);
      #12;
      checkOutput("rst_req", 32'(dbus_req), 32'd0);
      checkOutput("rst_we", 32'(dbus_we), 32'd0);
      checkOutput("rst_addr", dbus_addr, 32'd0);
      checkOutput("rst_sel", 32'(dbus_sel), 32'd0);
      checkOutput("rst_wdata", dbus_wdata, 32'd0);
      checkOutput("rst_stall", 32'(stallreq), 32'd0);
      checkOutput("rst_exc", 32'(exc_align), 32'd0);
      checkOutput("rst_mem_wd", 32'(mem_wd), 32'd0);
      checkOutput("rst_mem_wreg", 32'(mem_wreg), 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(OpNone, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

      runMemOp(OpLW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
      runMemOp(OpLB, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0);
      runMemOp(OpLBU, 32'h0000_0103, 32'h0, 32'h0000_00F0, 1);
      runMemOp(OpSH, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0);
      runMisaligned(OpLW, 32'h0000_0102);
      runPassthrough(OpNone, 5'd7, 1'b1, 32'h0000_0055, 1'b1);
      runPassthrough(OpNone, 5'd7, 1'b1, 32'h0000_0055, 1'b0);
      runMemOp(OpLH, 32'h0000_0400, 32'h0, 32'h8001_7FFE, 0);

      // Reset lands in the second BUSY cycle; the late ack must be ignored.
      @(negedge clk);
      applyStimulus(OpLW, 32'h0000_0300, 32'h0, 5'd4, 1'b1, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("prerst_req", 32'(dbus_req), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_req", 32'(dbus_req), 32'd0);
      checkOutput("midrst_stall", 32'(stallreq), 32'd0);
      checkOutput("midrst_wreg", 32'(mem_wreg), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(OpNone, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0000_0077);
      dbus_ack   = 1'b1;
      dbus_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      dbus_ack = 1'b0;
      #1;
      checkOutput("lateack_wdata", mem_wdata, 32'h0000_0077);
      checkOutput("lateack_req", 32'(dbus_req), 32'd0);
      checkOutput("lateack_stall", 32'(stallreq), 32'd0);
      runMemOp(OpLW, 32'h0000_0300, 32'h0, 32'h0102_0304, 0);

      for (int i = 0; i < 60; i++) begin
         int          op    = int'($urandom_range(0, 15));
         logic [31:0] addr  = $urandom;
         int          delay = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         if (opSize(op) == 0)
            runPassthrough(op, 5'($urandom), 1'($urandom), $urandom, 1'($urandom));
         else if (!isAligned(op, addr))
            runMisaligned(op, addr);
         else
            runMemOp(op, addr, $urandom, $urandom, delay);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
